bram_dp: RTL and testbench
==========================

# bram_dp

Parametrised dual-port block RAM for the UART test designs: one read/write port (A) and one read-only port (B) on a single clock. It adds a hardware clear engine that fills every word with a programmable value after reset or on request, plus a selectable read-during-write mode. It sits between the UART receive/transmit logic and any consumer that needs to read the buffer while it is being filled.

## Interface
- WIDTH, 8: data word width in bits (≥1).
- LEN, 2048: number of words (≥2; need not be a power of two).
- FILL, {WIDTH{1'b1}}: value written to every word by the clear engine.
- RDW_MODE, 0: port A same-address read-during-write; 0 = read-first (old data), 1 = write-first (new data).
- Derived AW = max(1, ceil(log2(LEN))).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  one-cycle request to re-fill the RAM with FILL; honoured only when idle.
- busy  out  1  high while the clear engine owns the array.
- a_en  in  1  port A access enable.
- a_we  in  1  port A write enable; qualified by a_en.
- a_addr  in  AW  port A address.
- a_din  in  WIDTH  port A write data.
- a_dout  out  WIDTH  port A read data.
- a_valid  out  1  a_dout updated this cycle.
- b_en  in  1  port B read enable.
- b_addr  in  AW  port B address.
- b_dout  out  WIDTH  port B read data.
- b_valid  out  1  b_dout updated this cycle.

## Operation
- FSM states: IDLE and CLEAR. rst forces CLEAR with the sweep counter at 0.
- CLEAR: each cycle, write FILL to mem[counter] and increment the counter. On the cycle that writes LEN-1, go to IDLE. busy is 1 throughout CLEAR, including every cycle rst is high.
- IDLE: `clear`=1 enters CLEAR with counter 0 on the next edge. `clear` is ignored in CLEAR, so the sweep does not restart. If rst is asserted mid-sweep, the sweep restarts from address 0.
- While busy, a_en, a_we and b_en are ignored: no user writes occur, and a_valid and b_valid stay 0.
- Port A, a_en=1 and a_we=1: mem[a_addr] ← a_din. a_dout returns the old word when RDW_MODE=0 and a_din when RDW_MODE=1.
- Port A with a_en=1 and a_we=0, and port B with b_en=1: plain reads.
- Cross-port collision (A writes address X while B reads X in the same cycle): b_dout returns the old word, regardless of RDW_MODE.
- Out-of-range address (≥LEN): a write is dropped. A read returns FILL, with valid asserted as normal.
- When a port is not enabled, its dout holds its last value and its valid is 0.

## Timing
- Reset values: a_dout=0, b_dout=0, a_valid=0, b_valid=0, busy=1.
- Clear duration: after rst deasserts, busy stays high for exactly LEN cycles. The first user access is accepted on the edge after busy falls. A `clear` pulse while idle raises busy on the next edge, for LEN cycles.
- Read latency: 1 cycle. An enable sampled at edge N produces dout and valid=1 after edge N, and valid lasts one cycle per accepted access.
- Throughput: one access per port per cycle, with no back-pressure.

## Configuration
- BRAM_DP_OREG_EN defined: adds an output register stage on both ports. Read latency becomes 2 cycles. valid is pipelined alongside data. The extra stage resets to 0/invalid, and while busy it outputs valid=0.
- BRAM_DP_OREG_EN undefined: 1-cycle latency, as described above.

## Test plan
- Reset fill: WIDTH=8, LEN=16, FILL=8'hFF. Release rst, then count busy cycles → exactly 16. Read all 16 addresses on B → 8'hFF each, b_valid one cycle after each b_en.
- Write/read both ports: once idle, write A[5]=8'h3C, then read B[5] on the next cycle → b_dout=8'h3C, one cycle after b_en.
- Read-during-write: mem[7]=8'h11, then A writes 8'h22 to address 7. With RDW_MODE=0, a_dout=8'h11; with RDW_MODE=1, a_dout=8'h22. In the same cycle B reads address 7 → 8'h11. The following read → 8'h22.
- Clear request and gating: write 8'h00 to all words, pulse `clear`, and drive a_we=1 during the sweep → busy high for 16 cycles, no writes land, every word reads 8'hFF afterwards, and a_valid and b_valid stay 0 while busy.
- Reset mid-sweep: assert rst 5 cycles into a sweep, then release → busy lasts 16 more cycles. A second `clear` pulse during the sweep is ignored, so busy falls 16 cycles after the restart.
- Non-power-of-two depth: LEN=10. A write to address 12 is dropped. A read of address 12 → FILL with valid=1. With BRAM_DP_OREG_EN defined, read latency measures 2 cycles.

Source files
------------

// File: rtl/bram_dp.sv
// Dual-port block RAM: port A read/write, port B read-only, with a clear engine that fills every word
// with FILL after reset or on request. Define BRAM_DP_OREG_EN to add an output register stage.
module bram_dp #(
   parameter int                WIDTH    = 8,
   parameter int                LEN      = 2048,
   parameter logic [WIDTH-1:0]  FILL     = {WIDTH{1'b1}},
   parameter bit                RDW_MODE = 1'b0,
   localparam int               AW       = (LEN > 2) ? $clog2(LEN) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   output logic             busy,
   input  logic             a_en,
   input  logic             a_we,
   input  logic [AW-1:0]    a_addr,
   input  logic [WIDTH-1:0] a_din,
   output logic [WIDTH-1:0] a_dout,
   output logic             a_valid,
   input  logic             b_en,
   input  logic [AW-1:0]    b_addr,
   output logic [WIDTH-1:0] b_dout,
   output logic             b_valid
);

   localparam logic [0:0]    IDLE  = 1'b0;
   localparam logic [0:0]    CLEAR = 1'b1;
   localparam logic [AW:0]   LEN_V = (AW + 1)'(LEN);
   localparam logic [AW-1:0] LAST  = AW'(LEN - 1);

   logic [0:0]       state;
   logic [AW-1:0]    cnt;
   logic [WIDTH-1:0] mem [LEN];

   logic             a_in, b_in, a_wr;
   logic [WIDTH-1:0] a_old, a_rd, b_rd;
   logic [WIDTH-1:0] a_q, b_q;
   logic             a_v, b_v;

   assign busy = rst | (state == CLEAR);

   // Addresses at or above LEN are outside the array: writes drop, reads see FILL.
   assign a_in  = {1'b0, a_addr} < LEN_V;
   assign b_in  = {1'b0, b_addr} < LEN_V;
   assign a_wr  = (state == IDLE) && a_en && a_we && a_in;
   assign a_old = a_in ? mem[a_addr] : FILL;
   assign a_rd  = (RDW_MODE && a_we && a_in) ? a_din : a_old;
   assign b_rd  = b_in ? mem[b_addr] : FILL;

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) begin
            mem[cnt] <= FILL;
         end else if (a_wr) begin
            mem[a_addr] <= a_din;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         a_v   <= 1'b0;
         b_v   <= 1'b0;
      end else begin
         a_v <= 1'b0;
         b_v <= 1'b0;
         if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
               state <= IDLE;
               cnt   <= '0;
            end
         end else begin
            if (clear) begin
               state <= CLEAR;
               cnt   <= '0;
            end
            if (a_en) begin
               a_v <= 1'b1;
               a_q <= a_rd;
            end
            if (b_en) begin
               b_v <= 1'b1;
               b_q <= b_rd;
            end
         end
      end
   end

`ifdef BRAM_DP_OREG_EN
   // Second stage only forwards results while idle, so nothing is presented during a sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_dout  <= '0;
         b_dout  <= '0;
         a_valid <= 1'b0;
         b_valid <= 1'b0;
      end else begin
         a_valid <= a_v && (state == IDLE);
         b_valid <= b_v && (state == IDLE);
         if (a_v && (state == IDLE)) a_dout <= a_q;
         if (b_v && (state == IDLE)) b_dout <= b_q;
      end
   end
`else
   assign a_dout  = a_q;
   assign b_dout  = b_q;
   assign a_valid = a_v;
   assign b_valid = b_v;
`endif

endmodule

// File: tb/tb_bram_dp.sv
// Bench for bram_dp: two instances (LEN=16 read-first, LEN=10 write-first) share one stimulus stream
// and are checked against an array model through per-port expected queues.
module tb_bram_dp;

   localparam logic [7:0] FILL = 8'hFF;
`ifdef BRAM_DP_OREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic       a_en = 1'b0, a_we = 1'b0, b_en = 1'b0;
   logic [3:0] a_addr = '0, b_addr = '0;
   logic [7:0] a_din = '0;

   logic [1:0] busy_o;
   logic       vld  [4];
   logic [7:0] dout [4];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit rst_seen = 1'b0;

   logic [7:0] mem_m [2][16];
   int         busy_left [2];
   logic [7:0] exp_q [4][$];
   int         due_q [4][$];
   logic [7:0] last_d [4];

   // clock / reset block
   always #5 clk = ~clk;

   bram_dp #(.WIDTH(8), .LEN(16), .FILL(FILL), .RDW_MODE(1'b0)) u0 (
      .clk(clk), .rst(rst), .clear(clear), .busy(busy_o[0]),
      .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
      .a_dout(dout[0]), .a_valid(vld[0]),
      .b_en(b_en), .b_addr(b_addr), .b_dout(dout[1]), .b_valid(vld[1])
   );

   bram_dp #(.WIDTH(8), .LEN(10), .FILL(FILL), .RDW_MODE(1'b1)) u1 (
      .clk(clk), .rst(rst), .clear(clear), .busy(busy_o[1]),
      .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
      .a_dout(dout[2]), .a_valid(vld[2]),
      .b_en(b_en), .b_addr(b_addr), .b_dout(dout[3]), .b_valid(vld[3])
   );

   task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int len_of(input int d);
      return (d == 0) ? 16 : 10;
   endfunction

   function automatic bit busy_exp(input int d);
      return rst || (busy_left[d] > 0);
   endfunction

   task automatic push(input int c, input logic [7:0] v);
      exp_q[c].push_back(v);
      due_q[c].push_back(cyc + LAT - 1);
   endtask

   // Reference model: one edge of the behaviour of instance d.
   task automatic model_edge(input int d);
      int len;
      logic [7:0] old_v, ea;
      bit ain, bin;
      len = len_of(d);
      if (LAT == 2 && !rst && busy_left[d] > 0) begin
         for (int c = 2 * d; c < 2 * d + 2; c++) begin
            while (due_q[c].size() > 0 && due_q[c][0] == cyc) begin
               void'(exp_q[c].pop_front());
               void'(due_q[c].pop_front());
            end
         end
      end
      if (rst) begin
         busy_left[d] = len;
         for (int c = 2 * d; c < 2 * d + 2; c++) begin
            exp_q[c].delete();
            due_q[c].delete();
         end
      end else if (busy_left[d] > 0) begin
         mem_m[d][len - busy_left[d]] = FILL;
         busy_left[d]--;
      end else begin
         ain = int'(a_addr) < len;
         bin = int'(b_addr) < len;
         if (b_en) push(2 * d + 1, bin ? mem_m[d][b_addr] : FILL);
         if (a_en) begin
            old_v = ain ? mem_m[d][a_addr] : FILL;
            ea = (a_we && ain && d == 1) ? a_din : old_v;
            push(2 * d, ea);
         end
         if (a_en && a_we && ain) mem_m[d][a_addr] = a_din;
         if (clear) busy_left[d] = len;
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      rst_seen = rst;
      model_edge(0);
      model_edge(1);
   end

   // Monitor / scoreboard: compares every output just after each active edge.
   always begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++)
         chk($sformatf("busy[%0d]", d), busy_o[d] == busy_exp(d), busy_o[d], busy_exp(d));
      for (int c = 0; c < 4; c++) begin
         if (rst_seen) last_d[c] = 8'h00;
         if (vld[c]) begin
            if (exp_q[c].size() == 0) begin
               chk($sformatf("unexpected_valid[%0d]", c), 1'b0, 1, 0);
            end else begin
               chk($sformatf("dout[%0d]", c), dout[c] == exp_q[c][0], dout[c], exp_q[c][0]);
               chk($sformatf("latency[%0d]", c), due_q[c][0] == cyc, cyc, due_q[c][0]);
               void'(exp_q[c].pop_front());
               void'(due_q[c].pop_front());
            end
            last_d[c] = dout[c];
         end else begin
            chk($sformatf("hold[%0d]", c), dout[c] == last_d[c], dout[c], last_d[c]);
            if (due_q[c].size() > 0 && due_q[c][0] <= cyc) begin
               chk($sformatf("missing_valid[%0d]", c), 1'b0, 0, exp_q[c][0]);
               void'(exp_q[c].pop_front());
               void'(due_q[c].pop_front());
            end
         end
      end
   end

   // driver tasks
   task automatic drive(input bit r, input bit clr, input bit ae, input bit awe,
                        input logic [3:0] aa, input logic [7:0] ad, input bit be, input logic [3:0] ba);
      @(negedge clk);
      rst = r; clear = clr; a_en = ae; a_we = awe; a_addr = aa; a_din = ad; b_en = be; b_addr = ba;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 4'd0, 8'h00, 0, 4'd0);
   endtask

   task automatic count_busy(input bit noisy, input int clr_at, output int n0, output int n1);
      int n = 0;
      n0 = 0;
      n1 = 0;
      while ((|busy_o) && n < 100) begin
         if (busy_o[0]) n0++;
         if (busy_o[1]) n1++;
         n++;
         if (noisy)
            drive(0, n == clr_at, 1, 1, 4'($urandom_range(0, 15)), 8'($urandom),
                  1, 4'($urandom_range(0, 15)));
         else
            drive(0, n == clr_at, 0, 0, 4'd0, 8'h00, 0, 4'd0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, n1;
      for (int c = 0; c < 4; c++) last_d[c] = 8'h00;
      busy_left[0] = 0;
      busy_left[1] = 0;

      // reset values
      drive(1, 0, 0, 0, 4'd0, 8'h00, 0, 4'd0);
      drive(1, 0, 0, 0, 4'd0, 8'h00, 0, 4'd0);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("reset_dout[%0d]", c), dout[c] == 8'h00, dout[c], 0);
         chk($sformatf("reset_valid[%0d]", c), vld[c] == 1'b0, vld[c], 0);
      end
      chk("reset_busy", busy_o == 2'b11, busy_o, 2'b11);

      // reset fill length
      idle();
      count_busy(0, 0, n0, n1);
      chk("fill_len0", n0 == 16, n0, 16);
      chk("fill_len1", n1 == 10, n1, 10);
      for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 4'd0, 8'h00, 1, 4'(i));

      // write on A, read back on B
      drive(0, 0, 1, 1, 4'd5, 8'h3C, 0, 4'd0);
      drive(0, 0, 0, 0, 4'd0, 8'h00, 1, 4'd5);

      // read-during-write, same and cross port
      drive(0, 0, 1, 1, 4'd7, 8'h11, 0, 4'd0);
      drive(0, 0, 1, 1, 4'd7, 8'h22, 1, 4'd7);
      drive(0, 0, 1, 0, 4'd7, 8'h00, 1, 4'd7);

      // out-of-range on the 10-deep instance
      drive(0, 0, 1, 1, 4'd12, 8'h5A, 0, 4'd0);
      drive(0, 0, 1, 0, 4'd12, 8'h00, 1, 4'd12);

      // clear request with accesses attempted during the sweep
      for (int i = 0; i < 16; i++) drive(0, 0, 1, 1, 4'(i), 8'h00, 0, 4'd0);
      drive(0, 1, 0, 0, 4'd0, 8'h00, 0, 4'd0);
      idle();
      count_busy(1, 0, n0, n1);
      chk("clear_len0", n0 == 16, n0, 16);
      for (int i = 0; i < 16; i++) drive(0, 0, 1, 0, 4'(i), 8'h00, 1, 4'(15 - i));

      // reset mid-sweep, then an ignored clear during the restarted sweep
      drive(0, 1, 0, 0, 4'd0, 8'h00, 0, 4'd0);
      repeat (5) idle();
      drive(1, 0, 0, 0, 4'd0, 8'h00, 0, 4'd0);
      idle();
      count_busy(0, 3, n0, n1);
      chk("restart_len0", n0 == 16, n0, 16);
      chk("restart_len1", n1 == 10, n1, 10);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
               1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom),
               1'($urandom), 4'($urandom_range(0, 15)));
      end
      drive(0, 0, 0, 0, 4'd0, 8'h00, 0, 4'd0);
      count_busy(0, 0, n0, n1);
      for (int i = 0; i < 16; i++) drive(0, 0, 1, 0, 4'(i), 8'h00, 1, 4'(i));
      repeat (4) idle();
      for (int c = 0; c < 4; c++)
         chk($sformatf("drain[%0d]", c), exp_q[c].size() == 0, exp_q[c].size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
